// File: rtl/pmt_photon_counter_if.sv
// Bin stream from the photon counter: one histogram bin per valid/ready transfer.
// The master holds valid/data/idx stable while ready is low.
interface pmt_photon_counter_if #(
    parameter int CNT_W = 8,
    parameter int IDX_W = 3
);
    logic             bin_valid;
    logic             bin_ready;
    logic [CNT_W-1:0] bin_data;
    logic [IDX_W-1:0] bin_idx;

    modport master (output bin_valid, output bin_data, output bin_idx, input bin_ready);
    modport slave  (input bin_valid, input bin_data, input bin_idx, output bin_ready);
endinterface

// File: rtl/pmt_photon_counter.sv
// Time-binned PMT photon counter: window of NUM_BINS*BIN_CYCLES cycles, PMT edge seen 2-3 cycles after the pin.
// Bins drain in order over valid/ready; valid is registered and holds through stalls.
module pmt_photon_counter #(
    parameter int BIN_CYCLES = 10000,
    parameter int NUM_BINS   = 8,
    parameter int CNT_W      = 8,
    parameter int THRESH     = 2,
    localparam int IDX_W     = $clog2(NUM_BINS),
    localparam int TOT_W     = CNT_W + IDX_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_pmt,
    input  logic                      i_start,
    output logic                      o_busy,
    pmt_photon_counter_if.master      bin_if,
    output logic [TOT_W-1:0]          o_total,
    output logic                      o_bright,
    output logic                      o_done
);
    localparam int TMR_W = $clog2(BIN_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BINS - 1);
    localparam logic [TOT_W:0]   THR      = (TOT_W+1)'(THRESH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic             r_s1, r_s2, r_s3;
    logic [TMR_W-1:0] r_timer;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_bins [NUM_BINS];
    logic             r_busy;
    logic             r_vld;
    logic             r_done;
    logic [TOT_W-1:0] r_total;
    logic             r_bright;

    logic             w_edge;
    logic [CNT_W-1:0] w_cur_next;
    logic [TOT_W-1:0] w_sum;

    assign w_edge = r_s2 & ~r_s3;

    // Sum uses the current bin's next value so an edge on the window's final cycle is included.
    always_comb begin
        w_cur_next = r_bins[r_idx];
        if (w_edge && (r_bins[r_idx] != '1)) begin
            w_cur_next = r_bins[r_idx] + 1'b1;
        end
        w_sum = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_sum = w_sum + TOT_W'(w_cur_next);
            end else begin
                w_sum = w_sum + TOT_W'(r_bins[i]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_timer  <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_vld    <= 1'b0;
            r_done   <= 1'b0;
            r_total  <= '0;
            r_bright <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else begin
            r_s1   <= i_pmt;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A START coinciding with the DONE pulse belongs to the old window and is dropped.
                    if (i_start && !r_done) begin
                        r_state <= S_ACQ;
                        r_busy  <= 1'b1;
                        r_timer <= '0;
                        r_idx   <= '0;
                        for (int i = 0; i < NUM_BINS; i++) begin
                            r_bins[i] <= '0;
                        end
                    end
                end
                S_ACQ: begin
                    r_bins[r_idx] <= w_cur_next;
                    if (r_timer == TMR_LAST) begin
                        r_timer <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_total  <= w_sum;
                            r_bright <= ({1'b0, w_sum} >= THR);
                            r_state  <= S_DRAIN;
                            r_vld    <= 1'b1;
                            r_idx    <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bin_if.bin_ready) begin
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_IDLE;
                            r_vld   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bin_if.bin_valid = r_vld;
    assign bin_if.bin_data  = r_vld ? r_bins[r_idx] : '0;
    assign bin_if.bin_idx   = r_idx;
    assign o_busy           = r_busy;
    assign o_total          = r_total;
    assign o_bright         = r_bright;
    assign o_done           = r_done;
endmodule

// File: tb/tb_pmt_photon_counter.sv
// Directed vector bench for pmt_photon_counter with BIN_CYCLES=100, NUM_BINS=4, CNT_W=4, THRESH=3.
module tb_pmt_photon_counter;
    localparam int BC = 100;
    localparam int NB = 4;
    localparam int CW = 4;
    localparam int TH = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       pmt;
    logic       start;
    logic       busy;
    logic       bright;
    logic       done;
    logic [5:0] total;

    always #5 clk = ~clk;

    pmt_photon_counter_if #(.CNT_W(CW), .IDX_W(2)) bif ();

    pmt_photon_counter #(
        .BIN_CYCLES (BC),
        .NUM_BINS   (NB),
        .CNT_W      (CW),
        .THRESH     (TH)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pmt   (pmt),
        .i_start (start),
        .o_busy  (busy),
        .bin_if  (bif.master),
        .o_total (total),
        .o_bright(bright),
        .o_done  (done)
    );

    typedef struct {
        int mode;   // 0 hold low, 1 period-20 square, 2 toggle each cycle, 3 single pulses
        int pa;
        int pb;
        int pc;
        int b0;
        int b1;
        int b2;
        int b3;
        int tot;
        int bri;
        bit stall;
    } vec_t;

    vec_t vt [6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mode  = 0;
    int   cyc   = 0;
    int   rel   = -1000;
    int   pa    = -1;
    int   pb    = -1;
    int   pc    = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic upd_pmt();
        case (mode)
            1:       pmt = ((cyc / 10) % 2) == 1;
            2:       pmt = (cyc % 2) == 1;
            3:       pmt = (rel == pa) || (rel == pb) || (rel == pc);
            default: pmt = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rel++;
        upd_pmt();
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_valid"}, int'(bif.bin_valid), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_total"}, int'(total), 0);
        chk({tag, "_bright"}, int'(bright), 0);
        chk({tag, "_data"},  int'(bif.bin_data), 0);
        chk({tag, "_idx"},   int'(bif.bin_idx), 0);
    endtask

    task automatic run_vec(input vec_t v, input int num);
        int eb [NB];
        int n;
        int acq;
        int g;
        int exp_idx;
        int stl;
        bit prev_stall;
        int prev_d;
        int prev_i;
        string tg;
        tg = $sformatf("v%0d", num);
        eb[0] = v.b0; eb[1] = v.b1; eb[2] = v.b2; eb[3] = v.b3;
        mode = v.mode; pa = v.pa; pb = v.pb; pc = v.pc;
        rel = -1000;
        bif.bin_ready = 1'b0;
        repeat (6) tick();
        chk({tg, "_busy_pre"}, int'(busy), 0);

        start = 1'b1;
        n = 0;
        tick();
        n++;
        start = 1'b0;
        rel = 0;
        upd_pmt();
        chk({tg, "_busy_on"}, int'(busy), 1);

        acq = 0;
        while (!bif.bin_valid && acq < 2000) begin
            acq++;
            start = v.stall && (rel == 150);
            tick();
            n++;
        end
        start = 1'b0;
        chk({tg, "_window_len"}, acq, NB * BC);

        exp_idx = 0; g = 0; stl = 0; prev_stall = 1'b0; prev_d = 0; prev_i = 0;
        while (exp_idx < NB && g < 500) begin
            if (!bif.bin_valid) begin
                chk({tg, "_valid_drop"}, int'(bif.bin_valid), 1);
                break;
            end
            if (prev_stall) begin
                chk({tg, "_stall_data"}, int'(bif.bin_data), prev_d);
                chk({tg, "_stall_idx"},  int'(bif.bin_idx), prev_i);
            end
            if (!v.stall) begin
                bif.bin_ready = 1'b1;
            end else if (exp_idx == 1 && stl < 10) begin
                bif.bin_ready = 1'b0;
                stl++;
            end else begin
                bif.bin_ready = ($urandom_range(0, 1) == 1);
            end
            start = v.stall && (g == 3);
            if (bif.bin_ready) begin
                chk({tg, "_bin_idx"},  int'(bif.bin_idx), exp_idx);
                chk({tg, "_bin_data"}, int'(bif.bin_data), eb[exp_idx]);
                exp_idx++;
            end
            prev_stall = !bif.bin_ready;
            prev_d = int'(bif.bin_data);
            prev_i = int'(bif.bin_idx);
            tick();
            n++;
            g++;
        end
        start = 1'b0;
        chk({tg, "_bins_xfer"}, exp_idx, NB);
        chk({tg, "_done"},   int'(done), 1);
        chk({tg, "_busy_off"}, int'(busy), 0);
        chk({tg, "_valid_off"}, int'(bif.bin_valid), 0);
        chk({tg, "_total"},  int'(total), v.tot);
        chk({tg, "_bright"}, int'(bright), v.bri);
        if (!v.stall) begin
            chk({tg, "_busy_len"}, n, NB * BC + 1 + NB);
        end
        // START during the DONE cycle must not open a window.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tg, "_done_pulse"}, int'(done), 0);
        chk({tg, "_start_on_done"}, int'(busy), 0);
        bif.bin_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1, -1, -1, -1, 5, 5, 5, 5, 20, 1, 1'b0};
        vt[1] = '{0, -1, -1, -1, 0, 0, 0, 0, 0, 0, 1'b0};
        vt[2] = '{2, -1, -1, -1, 15, 15, 15, 15, 60, 1, 1'b0};
        vt[3] = '{3, 250, 270, 297, 0, 0, 3, 0, 3, 1, 1'b0};
        vt[4] = '{3, 250, 297, -1, 0, 0, 2, 0, 2, 0, 1'b0};
        vt[5] = '{1, -1, -1, -1, 5, 5, 5, 5, 20, 1, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        pmt = 1'b0;
        bif.bin_ready = 1'b0;
        mode = 0;
        repeat (3) tick();
        chk_idle_zero("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vt[i], i);
        end

        // Abort a window mid-acquisition, then confirm a fresh window carries no residue.
        mode = 1;
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        rel = 0;
        repeat (150) tick();
        chk("abort_busy_before", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk_idle_zero("abort");
        rst = 1'b0;
        tick();
        chk("abort_idle", int'(busy), 0);
        run_vec(vt[0], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pmt_photon_counter.md
Name: pmt_photon_counter

Overview:
- Receive-side counterpart of the PMT pulse source.
- Synchronises the raw PMT line and counts rising edges (photon events) in a detection window that START opens.
- The window is split into NUM_BINS equal time bins, giving a time-resolved photon histogram for the on-board FNN qubit discriminator.
- Also produces a total count and a simple threshold bright/dark decision.
- Bin counts are streamed out over a valid/ready handshake.

Parameters:
- BIN_CYCLES, 10000: clock cycles per time bin (100 us at 100 MHz); must be at least 2.
- NUM_BINS, 8: bins per window; must be a power of two and at least 2.
- CNT_W, 8: width of each bin counter; counters saturate.
- THRESH, 2: total-count threshold for BRIGHT.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  synchronous reset, active-high.
- PMT  in  1  raw PMT pulse line, asynchronous to CLK.
- START  in  1  one-cycle pulse; opens a detection window.
- BUSY  out  1  high from window start until the last bin is handed off.
- BIN_VALID  out  1  bin word available.
- BIN_READY  in  1  consumer accepts the bin word.
- BIN_DATA  out  CNT_W  photon count of the presented bin.
- BIN_IDX  out  clog2(NUM_BINS)  index of the presented bin; 0 is the earliest.
- TOTAL  out  CNT_W+clog2(NUM_BINS)  sum of all bin counts of the last window.
- BRIGHT  out  1  TOTAL >= THRESH for the last window.
- DONE  out  1  one-cycle pulse after the final bin handshake.

Behaviour:
- Reset (RST high at a CLK edge) forces state IDLE. All outputs go to 0. Bin storage, timers and synchroniser flops clear. Reset applies in any state, including mid-window or mid-drain; any partial window is discarded.
- PMT path:
  - 2-flop synchroniser (s1, s2), then a third flop s3.
  - edge = s2 & ~s3.
  - A PMT rise that meets setup before edge k is seen as edge high during cycle k+2.
  - One edge counts as one photon. Edges at the full clock rate (alternating every cycle) are all counted.
- States: IDLE, ACQ, DRAIN.
- IDLE:
  - BUSY=0, BIN_VALID=0.
  - START=1 → ACQ. Bin timer, bin index and all bin counters clear; BUSY=1 from the next cycle.
- ACQ:
  - Bin timer counts 0..BIN_CYCLES-1.
  - Each cycle with edge=1 increments the current bin counter, saturating at 2^CNT_W-1.
  - An edge in the cycle where the timer = BIN_CYCLES-1 counts in the ending bin.
  - At timer = BIN_CYCLES-1 the timer wraps to 0 and the bin index advances.
  - At the last bin's final cycle: TOTAL latches the sum of all bins (including that final cycle's edge), BRIGHT latches TOTAL >= THRESH, and the state goes to DRAIN.
  - Window length is exactly NUM_BINS*BIN_CYCLES cycles.
  - Edges in IDLE or DRAIN are ignored.
- DRAIN:
  - BIN_VALID=1; BIN_DATA/BIN_IDX present bin 0 first.
  - On BIN_VALID & BIN_READY at a clock edge, advance to the next bin, or after bin NUM_BINS-1 go to IDLE with a one-cycle DONE pulse and BUSY=0.
  - While BIN_READY=0, BIN_VALID, BIN_DATA and BIN_IDX hold stable.
  - BIN_VALID must not depend combinationally on BIN_READY.
  - With BIN_READY tied high, drain takes NUM_BINS cycles.
- START while BUSY=1 is ignored: no restart, no effect on counts. START in the same cycle as DONE is also ignored; a new window needs START with BUSY=0.
- TOTAL/BRIGHT hold their last-window values until the next window's end or reset.
- Arithmetic: TOTAL is the sum of saturated bin values; its width cannot overflow.
- Expected implementation size: 150-250 lines.

Test Plan (bench parameters BIN_CYCLES=100, NUM_BINS=4, CNT_W=4, THRESH=3):
- PMT square wave, period 20 cycles, running before START; READY=1 → 5 edges per bin, BIN_DATA 5,5,5,5 at BIN_IDX 0..3, TOTAL=20, BRIGHT=1, DONE one cycle after bin 3 handshake, BUSY low 401+4 cycles after START.
- PMT held 0, START → bins 0,0,0,0; TOTAL=0; BRIGHT=0; window exactly 400 cycles.
- PMT toggled every cycle → 50 edges per bin, each bin saturates at 15; TOTAL=60; BRIGHT=1.
- Exactly 3 single pulses in bin 2 only, including one at timer=99 of bin 2 → bins 0,0,3,0 (the boundary edge stays in bin 2); TOTAL=3; BRIGHT=1 (>= boundary). Repeat with 2 pulses → BRIGHT=0.
- Back-pressure: BIN_READY low 10 cycles at bin 1, then random toggling → each bin transferred once, in order, with data stable while stalled; second START during ACQ and during DRAIN has no effect.
- RST asserted mid-ACQ (cycle 150) → next cycle all outputs 0, state IDLE; a fresh START with period-20 PMT gives 5,5,5,5 with no residue from the aborted window.
